rs_syndrome_engine: RTL and testbench

RS_SYNDROME_ENGINE -- requirements
Module: rs_syndrome_engine

---
 rtl/rs_pkg.sv | 30 +++
 rtl/rs_syndrome_engine_lane.sv | 41 ++++
 rtl/rs_syndrome_engine.sv | 122 ++++++++++++
 tb/tb_rs_syndrome_engine.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared GF(2^8) helpers, field defaults and the engine state type for the RS syndrome engine.
package rs_pkg;

  localparam logic [8:0] GF_POLY_DEFAULT = 9'h11D;

  typedef enum logic {StIdle, StAccum} state_e;

  // Shift-and-add product; used only with one constant operand so synthesis folds it to XORs.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b,
                                        input logic [8:0] poly);
    logic [7:0] p;
    logic [8:0] x;
    p = 8'h00;
    x = {1'b0, a};
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x[7:0];
      x = {x[7:0], 1'b0};
      if (x[8]) x ^= poly;
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_alpha_pow(input int unsigned e, input logic [8:0] poly);
    logic [7:0] r;
    r = 8'h01;
    for (int unsigned i = 0; i < e % 255; i++) r = gf_mul(r, 8'h02, poly);
    return r;
  endfunction

endpackage

// File: rtl/rs_syndrome_engine_lane.sv
// One syndrome accumulator: a beat-wide Horner step evaluating r(x) at alpha^EXP.
module syndrome_horner_lane
  import rs_pkg::*;
#(
  parameter int unsigned LANES   = 16,
  parameter int unsigned EXP     = 1,
  parameter logic [8:0]  GF_POLY = GF_POLY_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               first,
  input  logic [8*LANES-1:0] data,
  output logic [7:0]         next
);

  localparam logic [7:0] Step = gf_alpha_pow((EXP * LANES) % 255, GF_POLY);

  logic [7:0] acc_q;
  logic [7:0] term [LANES];

  // Lane 0 is the highest-degree symbol of the beat, so it carries the largest power.
  for (genvar k = 0; k < LANES; k++) begin : g_term
    localparam logic [7:0] Coef = gf_alpha_pow((EXP * (LANES - 1 - k)) % 255, GF_POLY);
    assign term[k] = gf_mul(data[8*k +: 8], Coef, GF_POLY);
  end

  always_comb begin
    next = gf_mul(first ? 8'h00 : acc_q, Step, GF_POLY);
    for (int k = 0; k < LANES; k++) next ^= term[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= 8'h00;
    end else if (load) begin
      acc_q <= next;
    end
  end

endmodule

// File: rtl/rs_syndrome_engine.sv
// Streaming Reed-Solomon syndrome engine: framing FSM, NSYM Horner lanes and a held result.
module rs_syndrome_engine
  import rs_pkg::*;
#(
  parameter int unsigned LANES   = 16,
  parameter int unsigned NSYM    = 16,
  parameter int unsigned FCR     = 1,
  parameter logic [8:0]  GF_POLY = GF_POLY_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sop,
  input  logic               in_eop,
  input  logic [8*LANES-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*NSYM-1:0]  out_syndromes,
  output logic               out_nonzero,
  output logic [15:0]        out_beats,
  output logic               out_restart
);

  state_e state_q, state_d;
  logic [15:0] beats_q, beats_d;
  logic        restart_q, restart_d;
  logic        out_valid_q, out_valid_d;
  logic [8*NSYM-1:0] out_synd_q;
  logic        out_nonzero_q;
  logic [15:0] out_beats_q;
  logic        out_restart_q;

  logic accept, take, finish;
  logic [7:0] next_synd [NSYM];
  logic [8*NSYM-1:0] synd_flat;

  for (genvar j = 0; j < NSYM; j++) begin : g_lane
    syndrome_horner_lane #(
      .LANES  (LANES),
      .EXP    (FCR + j),
      .GF_POLY(GF_POLY)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .load (take),
      .first(in_sop),
      .data (in_data),
      .next (next_synd[j])
    );
  end

  always_comb begin
    synd_flat = '0;
    for (int j = 0; j < NSYM; j++) synd_flat[8*j +: 8] = next_synd[j];
  end

  assign in_ready = !(out_valid_q && !out_ready);

  always_comb begin
    accept      = in_valid && in_ready;
    // Beats outside a frame are dropped unless they open one.
    take        = accept && (in_sop || (state_q == StAccum));
    finish      = take && in_eop;
    state_d     = state_q;
    beats_d     = beats_q;
    restart_d   = restart_q;
    out_valid_d = out_valid_q;

    if (take) begin
      if (in_sop) begin
        beats_d   = 16'd1;
        restart_d = (state_q == StAccum);
      end else if (beats_q != 16'hFFFF) begin
        beats_d = beats_q + 16'd1;
      end
    end

    unique case (state_q)
      StIdle:  if (take && !in_eop) state_d = StAccum;
      StAccum: if (take && in_eop) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (finish) begin
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      beats_q       <= 16'd0;
      restart_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      out_synd_q    <= '0;
      out_nonzero_q <= 1'b0;
      out_beats_q   <= 16'd0;
      out_restart_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beats_q     <= beats_d;
      restart_q   <= restart_d;
      out_valid_q <= out_valid_d;
      if (finish) begin
        out_synd_q    <= synd_flat;
        out_nonzero_q <= |synd_flat;
        out_beats_q   <= beats_d;
        out_restart_q <= restart_d;
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign out_syndromes = out_synd_q;
  assign out_nonzero   = out_nonzero_q;
  assign out_beats     = out_beats_q;
  assign out_restart   = out_restart_q;

endmodule

// File: tb/tb_rs_syndrome_engine.sv
// Bench for rs_syndrome_engine: symbol-level polynomial model plus directed literal checks.
module tb_rs_syndrome_engine;

  localparam int LANES = 16;
  localparam int NSYM  = 16;
  localparam int FCR   = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0, out_ready = 1'b1;
  logic [8*LANES-1:0] in_data = '0;
  logic in_ready, out_valid, out_nonzero, out_restart;
  logic [8*NSYM-1:0] out_syndromes;
  logic [15:0] out_beats;

  rs_syndrome_engine dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sop       (in_sop),
    .in_eop       (in_eop),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_syndromes(out_syndromes),
    .out_nonzero  (out_nonzero),
    .out_beats    (out_beats),
    .out_restart  (out_restart)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic started = 1'b0;

  int exp_t [255];
  int log_t [256];
  logic [7:0] cw [256];
  logic [7:0] gen [17];

  // Model state: the frame as a plain symbol list, evaluated symbol by symbol.
  logic       m_active = 1'b0, m_restart = 1'b0, m_valid = 1'b0;
  logic [7:0] m_syms [$];
  logic [15:0] m_beats = 16'd0;
  logic [8*NSYM-1:0] m_synd = '0;
  logic        m_nonzero = 1'b0, m_restart_out = 1'b0;
  logic [15:0] m_beats_out = 16'd0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [7:0] gf_mult(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return 8'(exp_t[(log_t[a] + log_t[b]) % 255]);
  endfunction

  function automatic logic [8*NSYM-1:0] model_synd();
    logic [8*NSYM-1:0] r;
    logic [7:0] x, s;
    r = '0;
    for (int j = 0; j < NSYM; j++) begin
      x = 8'(exp_t[(FCR + j) % 255]);
      s = 8'h00;
      foreach (m_syms[i]) s = gf_mult(s, x) ^ m_syms[i];
      r[8*j +: 8] = s;
    end
    return r;
  endfunction

  task automatic model_step();
    logic rdy;
    if (rst) begin
      m_active = 1'b0;
      m_restart = 1'b0;
      m_valid = 1'b0;
      m_beats = 16'd0;
      m_syms.delete();
    end else begin
      rdy = !(m_valid && !out_ready);
      if (m_valid && out_ready) m_valid = 1'b0;
      if (in_valid && rdy) begin
        if (in_sop) begin
          m_restart = m_active;
          m_syms.delete();
          m_beats = 16'd0;
          m_active = 1'b1;
        end
        if (m_active) begin
          for (int k = 0; k < LANES; k++) m_syms.push_back(in_data[8*k +: 8]);
          if (m_beats != 16'hFFFF) m_beats++;
          if (in_eop) begin
            m_synd        = model_synd();
            m_nonzero     = (m_synd != '0);
            m_beats_out   = m_beats;
            m_restart_out = m_restart;
            m_valid       = 1'b1;
            m_active      = 1'b0;
          end
        end
      end
    end
  endtask

  always @(posedge clk or posedge rst) model_step();

  always @(negedge clk) begin
    if (started && !rst) begin
      check("in_ready", 128'(in_ready), 128'(!(m_valid && !out_ready)));
      check("out_valid", 128'(out_valid), 128'(m_valid));
      if (m_valid) begin
        check("syndromes", 128'(out_syndromes), 128'(m_synd));
        check("nonzero", 128'(out_nonzero), 128'(m_nonzero));
        check("beats", 128'(out_beats), 128'(m_beats_out));
        check("restart", 128'(out_restart), 128'(m_restart_out));
      end
    end
  end

  task automatic send(input logic [127:0] d, input logic s, input logic e);
    int n;
    logic acc;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sop   = s;
    in_eop   = e;
    do begin
      acc = !(m_valid && !out_ready);
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 20);
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got no acceptance after %0d cycles, required 1", n);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] cw_beat(input int b);
    logic [127:0] d;
    for (int k = 0; k < LANES; k++) d[8*k +: 8] = cw[16*b + k];
    return d;
  endfunction

  task automatic send_cw();
    for (int b = 0; b < 16; b++) send(cw_beat(b), b == 0, b == 15);
  endtask

  initial begin
    int x;
    logic [7:0] r [16];
    logic [7:0] fb, rt, keep;
    logic [127:0] d;

    x = 1;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = x;
      log_t[x] = i;
      x = x << 1;
      if (x >= 256) x = x ^ 'h11D;
    end

    gen[0] = 8'h01;
    for (int i = 1; i < 17; i++) gen[i] = 8'h00;
    for (int i = 0; i < 16; i++) begin
      rt = 8'(exp_t[(FCR + i) % 255]);
      for (int k = i + 1; k >= 1; k--) gen[k] = gen[k] ^ gf_mult(rt, gen[k-1]);
    end

    // RS(255,239) systematic codeword behind one leading zero pad symbol.
    for (int i = 0; i < 16; i++) r[i] = 8'h00;
    cw[0] = 8'h00;
    for (int i = 0; i < 239; i++) begin
      cw[1 + i] = 8'((i * 37 + 11) & 'hFF);
      fb = cw[1 + i] ^ r[0];
      for (int k = 0; k < 15; k++) r[k] = r[k+1] ^ gf_mult(fb, gen[k+1]);
      r[15] = gf_mult(fb, gen[16]);
    end
    for (int i = 0; i < 16; i++) cw[240 + i] = r[i];

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_syndromes", 128'(out_syndromes), 128'(0));
    check("rst_beats", 128'(out_beats), 128'(0));
    check("rst_nonzero", 128'(out_nonzero), 128'(0));
    check("rst_restart", 128'(out_restart), 128'(0));
    rst = 1'b0;
    started = 1'b1;
    #1;
    check("post_rst_in_ready", 128'(in_ready), 128'(1));

    send('0, 1'b1, 1'b1);
    check("zero_valid", 128'(out_valid), 128'(1));
    check("zero_synd", 128'(out_syndromes), 128'(0));
    check("zero_nonzero", 128'(out_nonzero), 128'(0));
    check("zero_beats", 128'(out_beats), 128'(1));

    d = '0;
    d[127:120] = 8'h01;
    send(d, 1'b1, 1'b1);
    check("lane15_synd", 128'(out_syndromes), {16{8'h01}});
    d = '0;
    d[119:112] = 8'h01;
    send(d, 1'b1, 1'b1);
    check("lane14_s0", 128'(out_syndromes[7:0]), 128'(8'h02));
    check("lane14_s1", 128'(out_syndromes[15:8]), 128'(8'h04));
    check("lane14_s2", 128'(out_syndromes[23:16]), 128'(8'h08));

    send_cw();
    check("cw_nonzero", 128'(out_nonzero), 128'(0));
    check("cw_synd", 128'(out_syndromes), 128'(0));
    check("cw_beats", 128'(out_beats), 128'(16));
    keep = cw[100];
    cw[100] = cw[100] ^ 8'h5A;
    send_cw();
    check("flip_nonzero", 128'(out_nonzero), 128'(1));
    cw[100] = keep;
    idle(2);

    out_ready = 1'b0;
    d = '0;
    d[127:120] = 8'h01;
    send(d, 1'b1, 1'b1);
    d = '0;
    d[119:112] = 8'h01;
    in_data = d;
    in_valid = 1'b1;
    in_sop = 1'b1;
    in_eop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("stall_in_ready", 128'(in_ready), 128'(0));
      check("stall_synd", 128'(out_syndromes), {16{8'h01}});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("nobubble_valid", 128'(out_valid), 128'(1));
    check("nobubble_s0", 128'(out_syndromes[7:0]), 128'(8'h02));
    idle(2);

    send({16{8'h33}}, 1'b0, 1'b1);
    idle(1);
    check("stray_ignored", 128'(out_valid), 128'(0));
    send({16{8'h11}}, 1'b1, 1'b0);
    send({16{8'h22}}, 1'b0, 1'b0);
    send({16{8'h44}}, 1'b1, 1'b0);
    send({16{8'h55}}, 1'b0, 1'b1);
    check("restart_valid", 128'(out_valid), 128'(1));
    check("restart_beats", 128'(out_beats), 128'(2));
    check("restart_flag", 128'(out_restart), 128'(1));
    idle(2);

    for (int b = 0; b < 8; b++) send(cw_beat(b), b == 0, 1'b0);
    rst = 1'b1;
    #3;
    check("midrst_valid", 128'(out_valid), 128'(0));
    check("midrst_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    send(cw_beat(8), 1'b0, 1'b1);
    idle(1);
    check("post_rst_needs_sop", 128'(out_valid), 128'(0));
    send_cw();
    check("clean_nonzero", 128'(out_nonzero), 128'(0));
    check("clean_restart", 128'(out_restart), 128'(0));
    check("clean_beats", 128'(out_beats), 128'(16));
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
